seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset; synchronous and active-low.
REQ-003 SHALL have port: run  in  1  start request, sampled in IDLE.
REQ-004 SHALL have port: halt_req  in  1  stop request, honoured at instruction boundary.
REQ-005 SHALL have port: imem_req  out  1  fetch request to instruction memory.
REQ-006 SHALL have port: imem_addr  out  4  fetch address, equals PC.
REQ-007 SHALL have port: imem_valid  in  1  memory response strobe, imem_rdata valid this cycle.
REQ-008 SHALL have port: imem_rdata  in  11  fetched instruction word.
REQ-009 SHALL have port: INS  out  11  instruction register, drives instruction decoder.
REQ-010 SHALL have port: dec_write_en  in  1  decoder's write_en for current INS.
REQ-011 SHALL have port: alu_zero  in  1  ALU zero flag for current INS operands.
REQ-012 SHALL have port: rf_we  out  1  register-file write strobe.
REQ-013 SHALL have port: busy  out  1  high in any state except IDLE and HALT.
REQ-014 SHALL have port: RETIRED  out  8  retired-instruction count.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-016 IDLE: SHALL go to FETCH when run=1; else stay.
REQ-017 FETCH: SHALL hold imem_req=1 and imem_addr=PC until imem_valid=1, then load INS<=imem_rdata and go to DECODE; no timeout.
REQ-018 DECODE: SHALL last exactly one cycle with INS stable, then go to EXEC.
REQ-019 EXEC: SHALL last exactly one cycle; rf_we=dec_write_en in EXEC only, 0 in every other state.
REQ-020 Opcode is INS[10:8]; branch opcode 3'b100 SHALL set PC<=INS[7:4] in EXEC when alu_zero=1, else PC<=PC+1.
REQ-021 All non-branch opcodes, including noop 3'b011, SHALL set PC<=PC+1 in EXEC.
REQ-022 PC increment SHALL wrap 4'hF to 4'h0 without flag or stall.
REQ-023 RETIRED SHALL increment by 1 at each EXEC exit and saturate at 8'hFF.
REQ-024 EXEC exit SHALL go to HALT if halt_req=1 in that EXEC cycle, else to FETCH.
REQ-025 halt_req asserted in FETCH or DECODE SHALL NOT abort; current instruction completes, then HALT iff halt_req still 1 in EXEC.
REQ-026 HALT: SHALL go to FETCH when run=1 and halt_req=0, keeping PC and RETIRED; else stay.
REQ-027 imem_valid outside FETCH SHALL be ignored; INS SHALL change only on FETCH exit.
REQ-028 Fetch-to-retire latency SHALL be (FETCH wait cycles) + 2 cycles; with imem_valid in first FETCH cycle, 3 cycles per instruction.

Reset
REQ-029 rst_n=0 at a rising edge SHALL, in any state including mid-fetch, set state=IDLE, PC=0, INS=0, RETIRED=0.
REQ-030 During and after reset until run: imem_req=0, imem_addr=0, rf_we=0, busy=0.
REQ-031 Reset SHALL take priority over run, halt_req and imem_valid in the same cycle.

Configuration
REQ-032 Macro SEQ_CTRL_SINGLE_STEP_EN, when defined, SHALL add input step (1 bit) and state PAUSE; EXEC exit goes to PAUSE instead of FETCH, and PAUSE goes to FETCH on step=1 (halt_req=1 in PAUSE goes to HALT, taking priority over step).
REQ-033 Without SEQ_CTRL_SINGLE_STEP_EN, SHALL have no step port and no PAUSE state; behaviour per REQ-024.

Verification
REQ-034 Reset, run=1, imem_valid always 1, mem[0]=11'b00000000000 -> INS loaded cycle 2, rf_we=1 one cycle in EXEC, PC=1, RETIRED=1.
REQ-035 mem[0]=11'b10001010000, alu_zero=1 -> PC=4'hA after EXEC, rf_we=0; repeat with alu_zero=0 -> PC=1.
REQ-036 imem_valid held 0 for 5 FETCH cycles -> imem_req stays 1, imem_addr stable, INS unchanged until sixth cycle.
REQ-037 PC=4'hF with non-branch -> PC=0 next; 300 instructions -> RETIRED=8'hFF.
REQ-038 halt_req pulsed in DECODE only -> no HALT; held through EXEC -> HALT, busy=0, rf_we=0; run=1, halt_req=0 -> FETCH resumes at saved PC.
REQ-039 rst_n=0 mid-FETCH with imem_valid=1 -> next cycle IDLE, PC=0, INS=0, RETIRED=0; with SEQ_CTRL_SINGLE_STEP_EN, one step pulse per instruction and no fetch without it.

Source files
------------

// File: rtl/seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_ctrl
//  Purpose  : Instruction sequencer. Fetches an 11-bit instruction from a
//             16-entry instruction memory, holds it in INS for one decode
//             cycle, executes it for one cycle, then advances or branches
//             the PC and counts retired instructions.
//
//  Ports    : clk          - sole clock, rising edge
//             rst_n        - synchronous active-low reset
//             run          - start request (IDLE / HALT)
//             halt_req     - stop request, honoured at the EXEC boundary
//             step         - single-step advance (optional build only)
//             imem_req     - fetch request, high throughout FETCH
//             imem_addr    - fetch address (current PC)
//             imem_valid   - memory response strobe
//             imem_rdata   - fetched instruction word
//             INS          - instruction register, feeds the decoder
//             dec_write_en - decoder write enable for current INS
//             alu_zero     - ALU zero flag for current INS
//             rf_we        - register-file write strobe (EXEC only)
//             busy         - high in every state except IDLE and HALT
//             RETIRED      - saturating retired-instruction count
//
//  Build    : define SEQ_CTRL_SINGLE_STEP_EN to add the step input and a
//             PAUSE state entered after every EXEC.
//
//  Revision : 1.0 - initial release
// ============================================================================
module seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        halt_req,
`ifdef SEQ_CTRL_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        imem_req,
    output logic [3:0]  imem_addr,
    input  logic        imem_valid,
    input  logic [10:0] imem_rdata,
    output logic [10:0] INS,
    input  logic        dec_write_en,
    input  logic        alu_zero,
    output logic        rf_we,
    output logic        busy,
    output logic [7:0]  RETIRED
);

    localparam logic [2:0] c_OP_BRANCH   = 3'b100;
    localparam logic [7:0] c_RETIRED_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
`ifdef SEQ_CTRL_SINGLE_STEP_EN
        ,
        ST_PAUSE  = 3'd5
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_pc;
    logic [3:0]  w_pc_next;
    logic [10:0] r_ins;
    logic [7:0]  r_retired;
    logic        w_load_ins;
    logic        w_retire;
    logic        w_take_branch;

    // Branch resolves against the flag presented during EXEC.
    assign w_take_branch = (r_ins[10:8] == c_OP_BRANCH) && alu_zero;

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load_ins   = 1'b0;
        w_retire     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // No timeout: wait as long as memory needs.
                if (imem_valid) begin
                    w_load_ins   = 1'b1;
                    w_state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_state_next = ST_EXEC;
            end

            ST_EXEC: begin
                w_retire  = 1'b1;
                // 4-bit add wraps F -> 0 naturally.
                w_pc_next = w_take_branch ? r_ins[7:4] : (r_pc + 4'd1);
                if (halt_req) begin
                    w_state_next = ST_HALT;
                end else begin
`ifdef SEQ_CTRL_SINGLE_STEP_EN
                    w_state_next = ST_PAUSE;
`else
                    w_state_next = ST_FETCH;
`endif
                end
            end

            ST_HALT: begin
                if (run && !halt_req) begin
                    w_state_next = ST_FETCH;
                end
            end

`ifdef SEQ_CTRL_SINGLE_STEP_EN
            ST_PAUSE: begin
                // A stop request outranks a step request.
                if (halt_req) begin
                    w_state_next = ST_HALT;
                end else if (step) begin
                    w_state_next = ST_FETCH;
                end
            end
`endif

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= 4'd0;
            r_ins     <= 11'd0;
            r_retired <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_load_ins) begin
                r_ins <= imem_rdata;
            end
            if (w_retire && (r_retired != c_RETIRED_MAX)) begin
                r_retired <= r_retired + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req  = (r_state == ST_FETCH);
    assign imem_addr = r_pc;
    assign INS       = r_ins;
    assign rf_we     = (r_state == ST_EXEC) && dec_write_en;
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign RETIRED   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_ctrl
//  Purpose  : Self-checking bench for seq_ctrl. An instruction-level model
//             (PC, INS, retired count, memory image) predicts every
//             observable output cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        halt_req;
`ifdef SEQ_CTRL_SINGLE_STEP_EN
    logic        step;
`endif
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_valid;
    logic [10:0] imem_rdata;
    logic [10:0] INS;
    logic        dec_write_en;
    logic        alu_zero;
    logic        rf_we;
    logic        busy;
    logic [7:0]  RETIRED;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [10:0] mem [16];
    int          m_pc;
    int          m_ret;
    logic [10:0] m_ins;

    always #5 clk = ~clk;

    seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .halt_req     (halt_req),
`ifdef SEQ_CTRL_SINGLE_STEP_EN
        .step         (step),
`endif
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .INS          (INS),
        .dec_write_en (dec_write_en),
        .alu_zero     (alu_zero),
        .rf_we        (rf_we),
        .busy         (busy),
        .RETIRED      (RETIRED)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset with every competing input asserted; reset must win.
    task automatic do_reset();
        rst_n        = 1'b0;
        run          = 1'b1;
        halt_req     = 1'b1;
        imem_valid   = 1'b1;
        imem_rdata   = 11'($urandom);
        dec_write_en = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy",    32'(busy),      0);
        chk("rst_req",     32'(imem_req),  0);
        chk("rst_addr",    32'(imem_addr), 0);
        chk("rst_rfwe",    32'(rf_we),     0);
        chk("rst_ins",     32'(INS),       0);
        chk("rst_retired", 32'(RETIRED),   0);
        rst_n      = 1'b1;
        run        = 1'b0;
        halt_req   = 1'b0;
        imem_valid = 1'b0;
        m_pc  = 0;
        m_ret = 0;
        m_ins = 11'd0;
        @(negedge clk);
        #1;
        chk("idle_busy", 32'(busy),     0);
        chk("idle_req",  32'(imem_req), 0);
        chk("idle_rfwe", 32'(rf_we),    0);
    endtask

    // From IDLE or HALT: pulse run for one cycle; lands in FETCH.
    task automatic start();
        run      = 1'b1;
        halt_req = 1'b0;
        #1;
        chk("pre_start_busy", 32'(busy), 0);
        @(negedge clk);
        run = 1'b0;
    endtask

    // One full instruction, starting at a negedge while the DUT is in FETCH.
    task automatic do_instr(input int waits, input bit zero, input bit we,
                            input bit hd, input bit he);
        logic [10:0] word;
        word = mem[m_pc];
        for (int i = 0; i <= waits; i++) begin
            imem_valid   = (i == waits);
            imem_rdata   = (i == waits) ? word : 11'($urandom);
            halt_req     = 1'($urandom);
            dec_write_en = 1'($urandom);
            alu_zero     = 1'($urandom);
            #1;
            chk("fetch_req",  32'(imem_req),  1);
            chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
            chk("fetch_ins",  32'(INS),       32'(m_ins));
            chk("fetch_rfwe", 32'(rf_we),     0);
            chk("fetch_busy", 32'(busy),      1);
            @(negedge clk);
        end
        // DECODE: strobes here must be ignored
        imem_valid   = 1'($urandom);
        imem_rdata   = 11'($urandom);
        halt_req     = hd;
        dec_write_en = 1'b1;
        alu_zero     = 1'($urandom);
        #1;
        chk("dec_ins",  32'(INS),      32'(word));
        chk("dec_req",  32'(imem_req), 0);
        chk("dec_rfwe", 32'(rf_we),    0);
        chk("dec_busy", 32'(busy),     1);
        @(negedge clk);
        // EXEC
        imem_valid   = 1'($urandom);
        imem_rdata   = 11'($urandom);
        halt_req     = he;
        dec_write_en = we;
        alu_zero     = zero;
        #1;
        chk("exec_rfwe", 32'(rf_we),    32'(we));
        chk("exec_ins",  32'(INS),      32'(word));
        chk("exec_req",  32'(imem_req), 0);
        chk("exec_busy", 32'(busy),     1);
        @(negedge clk);
        // Model: branch opcode 100 with zero flag jumps, everything else steps.
        if (word[10:8] == 3'b100 && zero)
            m_pc = int'(word[7:4]);
        else
            m_pc = (m_pc + 1) % 16;
        m_ret = (m_ret < 255) ? m_ret + 1 : 255;
        m_ins = word;
        imem_valid   = 1'b0;
        halt_req     = 1'b0;
        dec_write_en = 1'b1;
        #1;
        chk("retired", 32'(RETIRED),   32'(m_ret));
        chk("pc",      32'(imem_addr), 32'(m_pc));
        chk("ins_hold", 32'(INS),      32'(m_ins));
        if (he) begin
            chk("halt_busy", 32'(busy),     0);
            chk("halt_rfwe", 32'(rf_we),    0);
            chk("halt_req",  32'(imem_req), 0);
        end else begin
`ifdef SEQ_CTRL_SINGLE_STEP_EN
            step = 1'b0;
            for (int k = 0; k < 2; k++) begin
                #1;
                chk("pause_req",  32'(imem_req), 0);
                chk("pause_busy", 32'(busy),     1);
                @(negedge clk);
            end
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            #1;
`endif
            chk("next_fetch", 32'(imem_req), 1);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        run          = 1'b0;
        halt_req     = 1'b0;
        imem_valid   = 1'b0;
        imem_rdata   = 11'd0;
        dec_write_en = 1'b0;
        alu_zero     = 1'b0;
`ifdef SEQ_CTRL_SINGLE_STEP_EN
        step         = 1'b0;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 11'($urandom);
        @(negedge clk);
        do_reset();

        // Simple write instruction from address 0
        mem[0] = 11'b00000000000;
        start();
        do_instr(0, 1'($urandom), 1'b1, 1'b0, 1'b0);

        // Branch taken / not taken
        do_reset();
        mem[0] = 11'b10001010000;
        start();
        do_instr(0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        start();
        do_instr(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Slow memory: five empty FETCH cycles
        do_instr(5, 1'b0, 1'b1, 1'b0, 1'b0);

        // Jump to F, then a noop must wrap PC to 0
        mem[m_pc] = 11'b10011110000;
        do_instr(0, 1'b1, 1'b0, 1'b0, 1'b0);
        mem[15] = 11'b01100000000;
        do_instr(1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Stop request only in DECODE: no halt
        do_instr(1, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        // Stop request held through EXEC: halt
        do_instr(0, 1'($urandom), 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run          = (k == 0);
            halt_req     = (k == 0);
            imem_valid   = 1'b1;
            imem_rdata   = 11'($urandom);
            dec_write_en = 1'b1;
            #1;
            chk("in_halt_busy", 32'(busy),      0);
            chk("in_halt_rfwe", 32'(rf_we),     0);
            chk("in_halt_ins",  32'(INS),       32'(m_ins));
            chk("in_halt_addr", 32'(imem_addr), 32'(m_pc));
            @(negedge clk);
        end
        imem_valid = 1'b0;
        start();
        do_instr(0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);

        // Randomized run long enough to saturate RETIRED
        for (int n = 0; n < 300; n++) begin
            if (n % 8 == 0) mem[$urandom_range(0, 15)] = 11'($urandom);
            do_instr($urandom_range(0, 2), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'b0);
        end
        chk("retired_sat", 32'(RETIRED), 32'hFF);

        // Reset in the middle of a FETCH with a valid response pending
        imem_valid = 1'b1;
        imem_rdata = 11'h7FF;
        rst_n      = 1'b0;
        run        = 1'b1;
        #1;
        chk("midfetch_req", 32'(imem_req), 1);
        @(negedge clk);
        #1;
        chk("midrst_ins",     32'(INS),       0);
        chk("midrst_retired", 32'(RETIRED),   0);
        chk("midrst_addr",    32'(imem_addr), 0);
        chk("midrst_busy",    32'(busy),      0);
        chk("midrst_req",     32'(imem_req),  0);
        rst_n      = 1'b1;
        run        = 1'b0;
        imem_valid = 1'b0;
        m_pc  = 0;
        m_ret = 0;
        m_ins = 11'd0;
        @(negedge clk);
        #1;
        chk("post_rst_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
